// File: rtl/hazard_fwd_if.sv
// Pipeline-side bundle for hazard_fwd_unit: ID sources, downstream producers, and the unit's
// stall/flush/forwarding outputs. The pipeline uses the master modport; the unit uses slave.
interface hazard_fwd_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_src2_used;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic                  exe_wb_en;
    logic                  exe_mem_r_en;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_wb_en;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_wb_en;
    logic [DATA_W-1:0]     wb_value;
    logic                  exe_br_taken;
    logic                  cnt_clr;
    logic                  stall;
    logic                  id_bubble;
    logic                  if_flush;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [DATA_W-1:0]     wb_hold;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_src2_used,
        output exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        output wb_dest, wb_wb_en, wb_value, exe_br_taken, cnt_clr,
        input  stall, id_bubble, if_flush, fwd_a, fwd_b, wb_hold, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_src2_used,
        input  exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        input  wb_dest, wb_wb_en, wb_value, exe_br_taken, cnt_clr,
        output stall, id_bubble, if_flush, fwd_a, fwd_b, wb_hold, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// RAW hazard detection, EXE forwarding selects, load-use stall, branch squash and perf counters.
// FORWARDING_EN: when defined, bypass paths are live; otherwise every RAW match stalls.
module hazard_fwd_src #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  used,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_wb_en,
    output logic                  hit_exe,
    output logic [1:0]            code
);
    logic live, hit_mem, hit_wb;

    // r0 reads never depend on a producer
    assign live    = id_valid && used && (src != '0);
    assign hit_exe = live && exe_wb_en && (exe_dest == src);
    assign hit_mem = live && mem_wb_en && (mem_dest == src);
    assign hit_wb  = live && wb_wb_en  && (wb_dest  == src);

    always_comb begin
        code = 2'd0;
        if (hit_exe)      code = 2'd1;
        else if (hit_mem) code = 2'd2;
        else if (hit_wb)  code = 2'd3;
    end
endmodule

module hazard_fwd_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16
) (
    input logic        clk,
    input logic        rst,
    hazard_fwd_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0][REG_ADDR_W-1:0] src;
    logic [1:0]                 used;
    logic [1:0]                 hit_exe;
    logic [1:0][1:0]            code;
    logic                       hazard, stall_c, bubble_c;
    logic [CNT_W-1:0]           stall_cnt, flush_cnt;

    assign src  = {bus.id_src2, bus.id_src1};
    assign used = {bus.id_src2_used, 1'b1};

    for (genvar g = 0; g < 2; g++) begin : g_src
        hazard_fwd_src #(.REG_ADDR_W(REG_ADDR_W)) u_src (
            .src      (src[g]),
            .used     (used[g]),
            .id_valid (bus.id_valid),
            .exe_dest (bus.exe_dest),
            .exe_wb_en(bus.exe_wb_en),
            .mem_dest (bus.mem_dest),
            .mem_wb_en(bus.mem_wb_en),
            .wb_dest  (bus.wb_dest),
            .wb_wb_en (bus.wb_wb_en),
            .hit_exe  (hit_exe[g]),
            .code     (code[g])
        );
    end

`ifdef FORWARDING_EN
    logic [1:0]        fwd_a_q, fwd_b_q;
    logic [DATA_W-1:0] wb_hold_q;

    // only a load in EXE has no value to bypass yet
    assign hazard = (|hit_exe) && bus.exe_mem_r_en;

    always_ff @(posedge clk) begin
        if (rst || bubble_c || !bus.id_valid) begin
            fwd_a_q <= 2'd0;
            fwd_b_q <= 2'd0;
        end else begin
            fwd_a_q <= code[0];
            fwd_b_q <= code[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)               wb_hold_q <= '0;
        else if (bus.wb_wb_en) wb_hold_q <= bus.wb_value;
    end

    assign bus.fwd_a   = fwd_a_q;
    assign bus.fwd_b   = fwd_b_q;
    assign bus.wb_hold = wb_hold_q;
`else
    wire unused_nofwd = ^{bus.wb_value, bus.exe_mem_r_en, hit_exe};

    assign hazard      = (code[0] != 2'd0) || (code[1] != 2'd0);
    assign bus.fwd_a   = 2'd0;
    assign bus.fwd_b   = 2'd0;
    assign bus.wb_hold = '0;
`endif

    // a taken branch squashes the stalled instruction, so it must not freeze
    assign stall_c       = hazard && !bus.exe_br_taken;
    assign bubble_c      = hazard || bus.exe_br_taken;
    assign bus.stall     = stall_c;
    assign bus.id_bubble = bubble_c;
    assign bus.if_flush  = bus.exe_br_taken;

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr)                   stall_cnt <= '0;
        else if (stall_c && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr)                            flush_cnt <= '0;
        else if (bus.exe_br_taken && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end

    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios with literal expectations, then
// random traffic compared every cycle against a rule-level model.
module tb_hazard_fwd_unit;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam logic [CW-1:0] CMAX = '1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    hazard_fwd_if #(.REG_ADDR_W(RW), .DATA_W(DW), .CNT_W(CW)) bus ();
    hazard_fwd_unit #(.REG_ADDR_W(RW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Forwarding code: index+1 of the first stage in {EXE, MEM, WB} writing the source, else 0.
    function automatic logic [1:0] ref_code(input logic [RW-1:0] s, input logic use_it);
        logic [RW-1:0] d[3];
        logic          e[3];
        d = '{bus.exe_dest, bus.mem_dest, bus.wb_dest};
        e = '{bus.exe_wb_en, bus.mem_wb_en, bus.wb_wb_en};
        if (!bus.id_valid || !use_it || s == '0) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (e[k] && d[k] == s) return 2'(k + 1);
        return 2'd0;
    endfunction

    logic [1:0] e_c1, e_c2;
    logic       e_hz, e_stall, e_bub;
    always_comb begin
        e_c1 = ref_code(bus.id_src1, 1'b1);
        e_c2 = ref_code(bus.id_src2, bus.id_src2_used);
        if (FWD) e_hz = (e_c1 == 2'd1 || e_c2 == 2'd1) && bus.exe_mem_r_en;
        else     e_hz = (e_c1 != 2'd0 || e_c2 != 2'd0);
        e_stall = e_hz && !bus.exe_br_taken;
        e_bub   = e_hz || bus.exe_br_taken;
    end

    logic [1:0]    m_fa, m_fb;
    logic [DW-1:0] m_hold;
    int            m_sc, m_fc;
    always @(posedge clk) begin
        if (rst) begin
            m_fa <= 0; m_fb <= 0; m_hold <= 0; m_sc <= 0; m_fc <= 0;
        end else begin
            m_fa   <= (FWD && !e_bub && bus.id_valid) ? e_c1 : 2'd0;
            m_fb   <= (FWD && !e_bub && bus.id_valid) ? e_c2 : 2'd0;
            m_hold <= !FWD ? '0 : (bus.wb_wb_en ? bus.wb_value : m_hold);
            m_sc   <= bus.cnt_clr ? 0 : (e_stall ? ((m_sc + 1 > int'(CMAX)) ? m_sc : m_sc + 1) : m_sc);
            m_fc   <= bus.cnt_clr ? 0 : (bus.exe_br_taken ? ((m_fc + 1 > int'(CMAX)) ? m_fc : m_fc + 1) : m_fc);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", bus.stall, e_stall);
            check("id_bubble", bus.id_bubble, e_bub);
            check("if_flush", bus.if_flush, bus.exe_br_taken);
            check("fwd_a", bus.fwd_a, m_fa);
            check("fwd_b", bus.fwd_b, m_fb);
            check("wb_hold", bus.wb_hold, m_hold);
            check("stall_cnt", bus.stall_cnt, 64'(m_sc));
            check("flush_cnt", bus.flush_cnt, 64'(m_fc));
        end
    end

    task automatic idle();
        bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_src2_used = 0;
        bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
        bus.mem_dest = 0; bus.mem_wb_en = 0; bus.wb_dest = 0; bus.wb_wb_en = 0;
        bus.wb_value = 0; bus.exe_br_taken = 0; bus.cnt_clr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_r5();
        bus.exe_dest = 5; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1;
        bus.id_valid = 1; bus.id_src1 = 1; bus.id_src2 = 5; bus.id_src2_used = 1;
    endtask

    initial begin
        idle();
        cyc(); cyc();
        rst = 0;
        chk_en = 1;
        check("rst_fwd_a", bus.fwd_a, 0);
        check("rst_fwd_b", bus.fwd_b, 0);
        check("rst_wb_hold", bus.wb_hold, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_flush_cnt", bus.flush_cnt, 0);

        // back-to-back ALU ops
        cyc(); idle();
        bus.exe_dest = 3; bus.exe_wb_en = 1;
        bus.id_valid = 1; bus.id_src1 = 3; bus.id_src2 = 4; bus.id_src2_used = 1;
        #1 check("t1_stall", bus.stall, FWD ? 0 : 1);
        cyc(); idle();
        #1 check("t1_fwd_a", bus.fwd_a, FWD ? 1 : 0);
        check("t1_fwd_b", bus.fwd_b, 0);

        // load-use, then the load reaches MEM
        cyc(); idle(); bus.cnt_clr = 1;
        cyc(); idle(); load_use_r5();
        #1 check("t2_stall", bus.stall, 1);
        check("t2_bubble", bus.id_bubble, 1);
        cyc(); idle();
        bus.mem_dest = 5; bus.mem_wb_en = 1;
        bus.id_valid = 1; bus.id_src1 = 1; bus.id_src2 = 5; bus.id_src2_used = 1;
        #1 check("t2_stall_next", bus.stall, FWD ? 0 : 1);
        check("t2_fwd_b_bubble", bus.fwd_b, 0);
        cyc(); idle();
        #1 check("t2_fwd_b_mem", bus.fwd_b, FWD ? 2 : 0);
        check("t2_stall_cnt", bus.stall_cnt, FWD ? 1 : 2);

        // WB bypass
        cyc(); idle();
        bus.wb_dest = 7; bus.wb_wb_en = 1; bus.wb_value = 32'hDEADBEEF;
        bus.id_valid = 1; bus.id_src1 = 7;
        cyc(); idle();
        #1 check("t3_fwd_a", bus.fwd_a, FWD ? 3 : 0);
        check("t3_wb_hold", bus.wb_hold, FWD ? 64'hDEADBEEF : 0);

        // r0 guard
        cyc(); idle();
        bus.exe_wb_en = 1; bus.exe_mem_r_en = 1; bus.mem_wb_en = 1; bus.wb_wb_en = 1;
        bus.id_valid = 1; bus.id_src2_used = 1;
        #1 check("t4_stall", bus.stall, 0);
        cyc(); idle();
        #1 check("t4_fwd_a", bus.fwd_a, 0);
        check("t4_fwd_b", bus.fwd_b, 0);

        // taken branch during load-use
        cyc(); idle(); bus.cnt_clr = 1;
        cyc(); idle(); load_use_r5(); bus.exe_br_taken = 1;
        #1 check("t5_flush", bus.if_flush, 1);
        check("t5_bubble", bus.id_bubble, 1);
        check("t5_stall", bus.stall, 0);
        cyc(); idle();
        #1 check("t5_flush_cnt", bus.flush_cnt, 1);
        check("t5_stall_cnt", bus.stall_cnt, 0);

        // saturation, then clear beats a simultaneous stall
        cyc(); idle(); load_use_r5();
        repeat ((1 << CW) + 3) cyc();
        check("t6_sat", bus.stall_cnt, 64'(CMAX));
        bus.cnt_clr = 1;
        cyc(); idle();
        #1 check("t6_clr", bus.stall_cnt, 0);
        cyc(); idle();
        bus.mem_dest = 2; bus.mem_wb_en = 1; bus.id_valid = 1; bus.id_src1 = 2;
        #1 check("t6_mem_stall", bus.stall, FWD ? 0 : 1);
        cyc(); idle();
        #1 check("t6_mem_fwd_a", bus.fwd_a, FWD ? 2 : 0);

        // random traffic on a small register range to provoke frequent matches
        repeat (1500) begin
            cyc();
            rst               = ($urandom_range(0, 99) == 0);
            bus.id_valid      = ($urandom_range(0, 7) != 0);
            bus.id_src1       = RW'($urandom_range(0, 3));
            bus.id_src2       = RW'($urandom_range(0, 3));
            bus.id_src2_used  = 1'($urandom);
            bus.exe_dest      = RW'($urandom_range(0, 3));
            bus.exe_wb_en     = 1'($urandom);
            bus.exe_mem_r_en  = 1'($urandom);
            bus.mem_dest      = RW'($urandom_range(0, 3));
            bus.mem_wb_en     = 1'($urandom);
            bus.wb_dest       = RW'($urandom_range(0, 3));
            bus.wb_wb_en      = 1'($urandom);
            bus.wb_value      = $urandom;
            bus.exe_br_taken  = ($urandom_range(0, 7) == 0);
            bus.cnt_clr       = ($urandom_range(0, 31) == 0);
        end
        cyc();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB), sitting beside the stage registers.
- Detects read-after-write hazards between the ID instruction and producers in EXE, MEM and WB.
- Produces registered forwarding selects for the EXE operand muxes and holds the retiring WB value for late bypass.
- Inserts load-use stalls and squashes wrong-path instructions on taken branches.
- Keeps saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 5, register index width; register 0 is hard-wired zero.
DATA_W, 32, datapath width of wb_value and wb_hold.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_ADDR_W  first source register of ID instruction
id_src2  in  REG_ADDR_W  second source register
id_src2_used  in  1  src2 is a register read (0 for immediate forms)
exe_dest  in  REG_ADDR_W  destination at ID/EXE register output
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
mem_dest  in  REG_ADDR_W  destination at EXE/MEM register output
mem_wb_en  in  1  MEM instruction writes back
wb_dest  in  REG_ADDR_W  destination at MEM/WB register output
wb_wb_en  in  1  WB instruction writes back
wb_value  in  DATA_W  value being written back
exe_br_taken  in  1  branch resolved taken in EXE
cnt_clr  in  1  clear both counters
stall  out  1  freeze PC and IF/ID register
id_bubble  out  1  load zero control into ID/EXE register
if_flush  out  1  clear IF/ID register
fwd_a  out  2  EXE operand A select, registered
fwd_b  out  2  EXE operand B select, registered
wb_hold  out  DATA_W  registered copy of last written-back value
stall_cnt  out  CNT_W  stall cycles, saturating
flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Match rule: source S matches stage X iff id_valid, X_wb_en, X_dest == S, and S != 0. src2 is considered only when id_src2_used.
- Load-use: id source matches EXE and exe_mem_r_en -> stall=1 and id_bubble=1 in the same cycle (combinational). The condition clears itself after one bubble, because the load moves to MEM.
- Taken branch: exe_br_taken -> if_flush=1 and id_bubble=1, same cycle. The flush overrides the load-use check: stall=0 that cycle, since the stalled instruction is being squashed.
- Forwarding codes for the next cycle, computed per source in ID with priority EXE > MEM > WB:
  - 1: EXE match. Producer will be at EXE/MEM when the consumer is in EXE.
  - 2: MEM match. Producer will be at MEM/WB.
  - 3: WB match. Use wb_hold.
  - 0: register file.
- fwd_a/fwd_b are registered every cycle and track the ID/EXE register, which is never frozen.
- fwd_a/fwd_b load 0 when rst, id_bubble, or !id_valid.
- wb_hold loads wb_value on each clock with wb_wb_en. It holds otherwise.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with exe_br_taken=1.
  - Both saturate at all-ones.
  - cnt_clr or rst -> 0. When cnt_clr and an increment occur in the same cycle, the clear wins.
- Reset values: fwd_a=0, fwd_b=0, wb_hold=0, stall_cnt=0, flush_cnt=0. Combinational outputs follow their inputs. Asserting rst mid-stall drops the registered state only.

Optional Feature:
FORWARDING_EN.
- Defined: behaviour as above.
- Undefined:
  - fwd_a and fwd_b are tied to 0; wb_hold is tied to 0 and its register is removed.
  - stall=1 and id_bubble=1 whenever any used ID source matches EXE, MEM or WB, whether or not the producer is a load.
  - Branch flush priority and the counters are unchanged.

Test Plan:
1. Back-to-back ALU ops: EXE writes r3 (exe_wb_en=1), ID reads src1=r3, src2=r4 -> no stall; next cycle fwd_a=1, fwd_b=0.
2. Load-use: EXE is a load to r5, ID reads src2=r5 with id_src2_used=1 -> stall=1, id_bubble=1 for exactly 1 cycle; next cycle fwd_b=0, following cycle fwd_b=2; stall_cnt=1.
3. WB bypass: wb_dest=r7, wb_wb_en=1, wb_value=0xDEADBEEF, ID reads r7 -> next cycle fwd_a=3 and wb_hold=0xDEADBEEF.
4. r0 guard: EXE, MEM and WB all write r0, ID reads r0/r0 -> stall=0, fwd_a=fwd_b=0.
5. Branch during load-use: load-use condition and exe_br_taken=1 together -> if_flush=1, id_bubble=1, stall=0; flush_cnt +1, stall_cnt unchanged.
6. Counters: force stall for 2^CNT_W+3 cycles -> stall_cnt saturates at all-ones. Then assert cnt_clr together with a stall -> stall_cnt=0. Without FORWARDING_EN, an MEM match on r2 -> stall=1 and fwd_a=0.
